// File: rtl/store_rmw_unit.sv
// Store narrowing unit for a word-only data memory: word stores write directly,
// byte/halfword stores go through a read-modify-write of the containing word.
module store_rmw_unit #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_wdata
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned HALF_W = 16;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_BAD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        MERGE,
        WRITE,
        ERR
    } state_t;

    state_t              state;
    logic [HALF_W-1:0]   lat_wdata;
    logic                lat_half;
    logic [1:0]          lat_lane;
    logic                req_bad_c;
    logic [DATA_W-1:0]   merged_c;

    // Illegal size or address not naturally aligned to the access size
    always_comb begin
        req_bad_c = 1'b0;
        if (req_size == SIZE_BAD)
            req_bad_c = 1'b1;
        else if (req_size == SIZE_HALF && req_addr[0])
            req_bad_c = 1'b1;
        else if (req_size == SIZE_WORD && req_addr[1:0] != 2'b00)
            req_bad_c = 1'b1;
    end

    // Little-endian lane replacement over the word just read back
    always_comb begin
        merged_c = mem_rdata;
        if (lat_half)
            merged_c[{lat_lane[1], 4'b0000} +: HALF_W] = lat_wdata;
        else
            merged_c[{lat_lane, 3'b000} +: 8] = lat_wdata[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            lat_wdata <= '0;
            lat_half  <= 1'b0;
            lat_lane  <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_wdata <= req_wdata[HALF_W-1:0];
                        lat_half  <= (req_size == SIZE_HALF);
                        lat_lane  <= req_addr[1:0];
                        req_ready <= 1'b0;
                        if (req_bad_c) begin
                            state <= ERR;
                            err   <= 1'b1;
                        end else begin
                            mem_addr <= req_addr[ADDR_W-1:2];
                            if (req_size == SIZE_WORD) begin
                                state     <= WRITE;
                                mem_wdata <= req_wdata;
                                mem_we    <= 1'b1;
                                done      <= 1'b1;
                            end else begin
                                state  <= READ;
                                mem_re <= 1'b1;
                            end
                        end
                    end
                end
                READ: begin
                    state  <= MERGE;
                    mem_re <= 1'b0;
                end
                MERGE: begin
                    state     <= WRITE;
                    mem_wdata <= merged_c;
                    mem_we    <= 1'b1;
                    done      <= 1'b1;
                end
                WRITE: begin
                    state     <= IDLE;
                    mem_we    <= 1'b0;
                    done      <= 1'b0;
                    req_ready <= 1'b1;
                end
                ERR: begin
                    state     <= IDLE;
                    err       <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    mem_re    <= 1'b0;
                    mem_we    <= 1'b0;
                    done      <= 1'b0;
                    err       <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

    // SIZE_BYTE is implied by the non-half, non-word path
    logic unused_c;
    assign unused_c = (SIZE_BYTE != 2'b00);

endmodule

// File: tb/tb_store_rmw_unit.sv
// Directed bench for store_rmw_unit: table of store requests against a small
// word memory, plus hand sequences for reset behaviour.
module tb_store_rmw_unit;

    localparam int unsigned ADDR_W = 32;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [1:0]        req_size;
    logic              done;
    logic              err;
    logic [ADDR_W-3:0] mem_addr;
    logic              mem_re;
    logic [31:0]       mem_rdata;
    logic              mem_we;
    logic [31:0]       mem_wdata;

    store_rmw_unit #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_size  (req_size),
        .done      (done),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory: read data valid the cycle after mem_re; writes applied by the stimulus process
    logic [31:0] mem [16];
    always @(posedge clk) begin
        if (mem_re)
            mem_rdata <= mem[mem_addr[3:0]];
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // kind: 0 word store, 1 sub-word RMW, 2 error
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        pre;
        logic [31:0] pre_val;
        int          kind;
        logic [31:0] exp_wdata;
        logic [29:0] exp_maddr;
    } vec_t;

    vec_t vecs [11];

    task automatic run_vec(input int idx, input vec_t v);
        int re_cyc, we_cyc, done_cyc, err_cyc, rdy_cyc, re_n, we_n, ovl;
        logic [31:0] we_data;
        logic [29:0] we_addr, re_addr;
        re_cyc = 0; we_cyc = 0; done_cyc = 0; err_cyc = 0; rdy_cyc = 0;
        re_n = 0; we_n = 0; ovl = 0; we_data = '0; we_addr = '0; re_addr = '0;
        if (v.pre)
            mem[v.addr[5:2]] = v.pre_val;
        check($sformatf("v%0d ready_before", idx), 64'(req_ready), 64'(1));
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_size  = v.size;
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_valid = 1'b0;
                req_addr  = ~v.addr;
                req_wdata = ~v.wdata;
                req_size  = ~v.size;
            end
            if (mem_re) begin
                re_n++;
                if (re_cyc == 0) re_cyc = c;
                re_addr = mem_addr;
            end
            if (mem_we) begin
                we_n++;
                we_cyc  = c;
                we_data = mem_wdata;
                we_addr = mem_addr;
                mem[mem_addr[3:0]] = mem_wdata;
            end
            if (done) done_cyc = c;
            if (err)  err_cyc  = c;
            if ((int'(mem_re) + int'(mem_we) + int'(err) > 1) || (done != mem_we)) ovl++;
            if (req_ready) begin
                rdy_cyc = c;
                break;
            end
        end
        check($sformatf("v%0d strobe_overlap", idx), 64'(ovl), 64'(0));
        case (v.kind)
            0: begin
                check($sformatf("v%0d we_cycle", idx),   64'(we_cyc),   64'(1));
                check($sformatf("v%0d done_cycle", idx), 64'(done_cyc), 64'(1));
                check($sformatf("v%0d re_count", idx),   64'(re_n),     64'(0));
                check($sformatf("v%0d err_cycle", idx),  64'(err_cyc),  64'(0));
                check($sformatf("v%0d wdata", idx),      64'(we_data),  64'(v.exp_wdata));
                check($sformatf("v%0d maddr", idx),      64'(we_addr),  64'(v.exp_maddr));
                check($sformatf("v%0d ready_cycle", idx), 64'(rdy_cyc), 64'(2));
            end
            1: begin
                check($sformatf("v%0d re_cycle", idx),   64'(re_cyc),   64'(1));
                check($sformatf("v%0d re_count", idx),   64'(re_n),     64'(1));
                check($sformatf("v%0d re_addr", idx),    64'(re_addr),  64'(v.exp_maddr));
                check($sformatf("v%0d we_cycle", idx),   64'(we_cyc),   64'(3));
                check($sformatf("v%0d done_cycle", idx), 64'(done_cyc), 64'(3));
                check($sformatf("v%0d we_count", idx),   64'(we_n),     64'(1));
                check($sformatf("v%0d wdata", idx),      64'(we_data),  64'(v.exp_wdata));
                check($sformatf("v%0d maddr", idx),      64'(we_addr),  64'(v.exp_maddr));
                check($sformatf("v%0d ready_cycle", idx), 64'(rdy_cyc), 64'(4));
            end
            default: begin
                check($sformatf("v%0d err_cycle", idx),  64'(err_cyc),  64'(1));
                check($sformatf("v%0d re_count", idx),   64'(re_n),     64'(0));
                check($sformatf("v%0d we_count", idx),   64'(we_n),     64'(0));
                check($sformatf("v%0d done_cycle", idx), 64'(done_cyc), 64'(0));
                check($sformatf("v%0d ready_cycle", idx), 64'(rdy_cyc), 64'(2));
            end
        endcase
    endtask

    initial begin
        int strobes;
        vecs[0]  = '{32'h0000_0010, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0,         0, 32'hDEAD_BEEF, 30'h4};
        vecs[1]  = '{32'h0000_0012, 32'hFFFF_FFAA, 2'b00, 1'b1, 32'h1122_3344, 1, 32'h11AA_3344, 30'h4};
        vecs[2]  = '{32'h0000_0012, 32'h0000_BEEF, 2'b01, 1'b1, 32'h1122_3344, 1, 32'hBEEF_3344, 30'h4};
        vecs[3]  = '{32'h0000_0010, 32'h0000_0055, 2'b00, 1'b0, 32'h0,         1, 32'hBEEF_3355, 30'h4};
        vecs[4]  = '{32'h0000_0013, 32'h0000_1234, 2'b01, 1'b0, 32'h0,         2, 32'h0,         30'h0};
        vecs[5]  = '{32'h0000_0012, 32'h1234_5678, 2'b10, 1'b0, 32'h0,         2, 32'h0,         30'h0};
        vecs[6]  = '{32'h0000_0010, 32'h1234_5678, 2'b11, 1'b0, 32'h0,         2, 32'h0,         30'h0};
        vecs[7]  = '{32'h0000_0017, 32'h1234_5677, 2'b00, 1'b1, 32'hA5A5_A5A5, 1, 32'h77A5_A5A5, 30'h5};
        vecs[8]  = '{32'h0000_0018, 32'hFFFF_1234, 2'b01, 1'b1, 32'hCAFE_F00D, 1, 32'hCAFE_1234, 30'h6};
        vecs[9]  = '{32'h0000_0019, 32'h0000_009A, 2'b00, 1'b0, 32'h0,         1, 32'hCAFE_9A34, 30'h6};
        vecs[10] = '{32'hFFFF_FFFC, 32'h0BAD_C0DE, 2'b10, 1'b0, 32'h0,         0, 32'h0BAD_C0DE, 30'h3FFF_FFFF};

        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem_rdata = 32'h0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_size  = 2'b00;

        // Reset state with clock running
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst req_ready", 64'(req_ready), 64'(1));
        check("rst strobes", 64'({mem_re, mem_we, done, err}), 64'(0));
        check("rst mem_addr", 64'(mem_addr), 64'(0));
        check("rst mem_wdata", 64'(mem_wdata), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // req_valid low: nothing happens
        req_addr = 32'h10;
        req_size = 2'b10;
        req_wdata = 32'h1;
        strobes = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (mem_re || mem_we || done || err || !req_ready) strobes++;
        end
        check("idle ignore", 64'(strobes), 64'(0));

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // Asynchronous reset clears outputs between edges
        #2 rst_n = 1'b0;
        #1;
        check("async mem_wdata", 64'(mem_wdata), 64'(0));
        check("async mem_addr", 64'(mem_addr), 64'(0));
        check("async ready", 64'(req_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset while a word write strobe is live
        req_valid = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h0000_0001;
        req_size  = 2'b10;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("abort word we_live", 64'(mem_we), 64'(1));
        #1 rst_n = 1'b0;
        #1;
        check("abort word we_done_clear", 64'({mem_we, done}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset during MERGE of a byte RMW: no write, no pulses
        req_valid = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'h0000_0077;
        req_size  = 2'b00;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("abort rmw re_live", 64'(mem_re), 64'(1));
        @(negedge clk);
        rst_n = 1'b0;
        strobes = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (mem_we || done || err) strobes++;
            @(negedge clk);
            if (c == 1) rst_n = 1'b1;
            if (mem_we || done || err) strobes++;
        end
        check("abort rmw no_write", 64'(strobes), 64'(0));
        check("abort rmw ready", 64'(req_ready), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/store_rmw_unit.md
# store_rmw_unit

Store-path companion to the immediate/load extender: narrows a 32-bit store operand to byte, halfword or word width and commits it to a word-only data memory (no byte enables). Sub-word stores use a read-modify-write sequence. Sits between the MEM stage and the data memory port. Handshakes with the pipeline via valid/ready and reports completion or misalignment by single-cycle pulses.

## Interface
- ADDR_W, 32, width of the byte address; memory word address is ADDR_W-2 bits
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous and active-low
- req_valid  in  1  store request present
- req_ready  out  1  unit can accept a request; high only in IDLE
- req_addr  in  ADDR_W  byte address of the store
- req_wdata  in  32  store operand; byte from [7:0], halfword from [15:0]
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- done  out  1  one-cycle pulse, coincident with the committing mem_we
- err  out  1  one-cycle pulse: misaligned or illegal request, nothing written
- mem_addr  out  ADDR_W-2  word address, req_addr[ADDR_W-1:2]
- mem_re  out  1  memory read strobe
- mem_rdata  in  32  read data, valid exactly one cycle after mem_re
- mem_we  out  1  memory write strobe
- mem_wdata  out  32  full word to write

## Operation
- States: IDLE, READ, MERGE, WRITE, ERR.
- IDLE: req_ready=1. On req_valid, latch addr, wdata, size and check:
  - size 11, halfword with addr[0]=1, or word with addr[1:0]!=0 -> ERR.
  - word -> WRITE, mem_wdata = req_wdata.
  - byte/halfword -> READ.
- READ: mem_re=1, mem_addr driven. -> MERGE.
- MERGE: capture mem_rdata and replace lanes, little-endian:
  - byte, k=addr[1:0]: bits [8k+7:8k] = wdata[7:0].
  - halfword, h=addr[1]: bits [16h+15:16h] = wdata[15:0].
  - all other bits unchanged from mem_rdata. Result registered into mem_wdata. -> WRITE.
- WRITE: mem_we=1, done=1. -> IDLE.
- ERR: err=1, no mem_re/mem_we. -> IDLE.
- mem_re, mem_we, done, err are registered state decodes and never overlap.
- mem_addr and mem_wdata hold their values outside strobes.
- Requests with req_valid low in IDLE are ignored. Inputs are sampled only at acceptance; later changes have no effect.

## Timing
- Reset (async assert, sync release internally by clocking): state IDLE, req_ready=1, mem_re=0, mem_we=0, done=0, err=0, mem_addr=0, mem_wdata=0.
- Accept at edge T (IDLE, req_valid=1):
  - word: mem_we and done high in cycle T+1; req_ready high again at T+2.
  - byte/half: mem_re in T+1, rdata sampled at end of T+2, mem_we and done in T+3; ready at T+4.
  - error: err in T+1; ready at T+2.
- Max throughput: one word store per 2 cycles, one sub-word store per 4 cycles.
- rst_n low mid-sequence: abort immediately. No pending mem_we is issued, and no done or err pulse is issued. Return to IDLE.
- No hazard handling across requests: each RMW completes its write before the next read, so back-to-back sub-word stores to the same word merge correctly.

## Test plan
- Reset: hold rst_n low and toggle clk -> req_ready=1, all strobes 0, mem_addr=0, mem_wdata=0. Assert rst_n low between edges -> outputs clear without a clock edge.
- Word store: addr=0x0000_0010, wdata=0xDEAD_BEEF, size=10 -> T+1: mem_we=1, done=1, mem_addr=0x4, mem_wdata=0xDEADBEEF; mem_re never high.
- Byte store: memory word 0x11223344 at word 0x4, addr=0x12, wdata=0xFFFF_FFAA, size=00 -> mem_re at T+1; mem_we at T+3 with mem_wdata=0x11AA3344 and done=1.
- Halfword store, then byte store, back-to-back to the same word 0x11223344:
  - half: addr=0x12, wdata=0x0000_BEEF -> write 0xBEEF3344.
  - byte: addr=0x10, wdata=0x55 -> write 0xBEEF3355.
- Errors: half at addr 0x13, word at addr 0x12, size=11 -> each gives err=1 at T+1, no mem_re/mem_we, and req_ready back at T+2.
- Reset mid-RMW: byte store accepted, rst_n low during MERGE -> mem_we and done never assert; IDLE with req_ready=1 after release.
